// File: rtl/output_port_arbiter_if.sv
// Handshake bundle between the input buffers and one output port's arbiter.
// The master modport is the arbiter side, which drives the crossbar selects and pop strobes.
interface output_port_arbiter_if #(
  parameter int NUM_PORTS = 5
);
  logic [NUM_PORTS-1:0] req_in;
  logic [NUM_PORTS-1:0] tail_in;
  logic                 ready_in;
  logic [NUM_PORTS-1:0] sel_out;
  logic [NUM_PORTS-1:0] rd_en_out;
  logic                 valid_out;
  logic                 busy_out;

  modport master (
    input  req_in, tail_in, ready_in,
    output sel_out, rd_en_out, valid_out, busy_out
  );

  modport slave (
    output req_in, tail_in, ready_in,
    input  sel_out, rd_en_out, valid_out, busy_out
  );
endinterface

// File: rtl/output_port_arbiter.sv
// Packet-granular round-robin arbiter for one router output port (N, E, W, S, L).
// The state register is the one-hot crossbar select; a tail transfer re-arbitrates in the same cycle.
module output_port_arbiter #(
  parameter int NUM_PORTS = 5
) (
  input logic                  clk,
  input logic                  rst,
  output_port_arbiter_if.master bus
);

  typedef enum logic [4:0] {
    IDLE  = 5'b00000,
    GNT_N = 5'b00001,
    GNT_E = 5'b00010,
    GNT_W = 5'b00100,
    GNT_S = 5'b01000,
    GNT_L = 5'b10000
  } state_t;

  state_t     state;
  logic [2:0] ptr;

  logic       found;
  logic [2:0] win;
  logic [3:0] idx;
  logic [2:0] ptr_nxt;
  state_t     win_state;
  logic       tail_xfer;

  // Search ptr, ptr+1, ... wrapping 4->0; the first requester found wins.
  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    idx   = 4'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= 4'(NUM_PORTS)) idx = idx - 4'(NUM_PORTS);
      if (!found && bus.req_in[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
  end

  assign win_state = state_t'(5'b00001 << win);
  assign ptr_nxt   = (win == 3'(NUM_PORTS - 1)) ? 3'd0 : win + 3'd1;

  assign bus.sel_out   = state;
  assign bus.busy_out  = |state;
  assign bus.rd_en_out = state & bus.req_in & {NUM_PORTS{bus.ready_in}};
  assign bus.valid_out = |bus.rd_en_out;

  // Only the granted port's tail bit can matter, since rd_en_out is a subset of sel_out.
  assign tail_xfer = |(bus.rd_en_out & bus.tail_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= win_state;
            ptr   <= ptr_nxt;
          end
        end
        default: begin
          // ptr already points past the holder, so it is lowest priority here.
          if (tail_xfer) begin
            if (found) begin
              state <= win_state;
              ptr   <= ptr_nxt;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  a_sel_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.sel_out));
  a_rd_subset: assert property (@(posedge clk) disable iff (rst)
    (bus.rd_en_out & ~bus.sel_out) == '0);
  a_valid_ready: assert property (@(posedge clk) disable iff (rst)
    bus.valid_out |-> bus.ready_in);
  a_busy_sel: assert property (@(posedge clk) disable iff (rst)
    bus.busy_out == (|bus.sel_out));

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: each step drives inputs, queues the expected
// select/transfer for that cycle, and checks it at the following falling edge.
module tb_output_port_arbiter;
  logic clk = 1'b0;
  logic rst;

  output_port_arbiter_if #(.NUM_PORTS(5)) bus ();

  output_port_arbiter #(.NUM_PORTS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [4:0] sel;
    logic       valid;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step(input string tag, input logic r, input logic [4:0] req,
                      input logic [4:0] tail, input logic rdy,
                      input logic [4:0] esel, input logic ev);
    exp_t       e;
    exp_t       o;
    logic [4:0] erd;
    rst         = r;
    bus.req_in  = req;
    bus.tail_in = tail;
    bus.ready_in = rdy;
    e.tag   = tag;
    e.sel   = esel;
    e.valid = ev;
    sb.push_back(e);
    @(negedge clk);
    o   = sb.pop_front();
    erd = o.valid ? o.sel : 5'b00000;
    checks++;
    assert (bus.sel_out === o.sel) else begin
      errors++;
      $error("FAIL %s sel_out got %b expected %b", o.tag, bus.sel_out, o.sel);
    end
    checks++;
    assert (bus.rd_en_out === erd) else begin
      errors++;
      $error("FAIL %s rd_en_out got %b expected %b", o.tag, bus.rd_en_out, erd);
    end
    checks++;
    assert (bus.valid_out === o.valid) else begin
      errors++;
      $error("FAIL %s valid_out got %b expected %b", o.tag, bus.valid_out, o.valid);
    end
    checks++;
    assert (bus.busy_out === (|o.sel)) else begin
      errors++;
      $error("FAIL %s busy_out got %b expected %b", o.tag, bus.busy_out, |o.sel);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with every port requesting, then release
    step("rst_a",   1, 5'b11111, 5'b00000, 1, 5'b00000, 0);
    step("rst_b",   1, 5'b11111, 5'b00000, 1, 5'b00000, 0);
    step("rel",     0, 5'b11111, 5'b00000, 1, 5'b00000, 0);

    // round robin with single-flit packets everywhere
    step("rr_n",    0, 5'b11111, 5'b11111, 1, 5'b00001, 1);
    step("rr_e",    0, 5'b11111, 5'b11111, 1, 5'b00010, 1);
    step("rr_w",    0, 5'b11111, 5'b11111, 1, 5'b00100, 1);
    step("rr_s",    0, 5'b11111, 5'b11111, 1, 5'b01000, 1);
    step("rr_l",    0, 5'b11111, 5'b11111, 1, 5'b10000, 1);
    step("rr_n2",   0, 5'b11111, 5'b11111, 1, 5'b00001, 1);

    // E holds for a 4-flit packet while L requests (L's tail flag is ignored)
    step("e_f1",    0, 5'b10010, 5'b10000, 1, 5'b00010, 1);
    step("e_f2",    0, 5'b10010, 5'b10000, 1, 5'b00010, 1);
    step("e_f3",    0, 5'b10010, 5'b10000, 1, 5'b00010, 1);
    step("e_tail",  0, 5'b10010, 5'b10010, 1, 5'b00010, 1);
    step("l_next",  0, 5'b10100, 5'b10000, 1, 5'b10000, 1);

    // W backpressure and a dropped request mid-packet
    step("w_f1",    0, 5'b00100, 5'b00000, 1, 5'b00100, 1);
    step("w_bp1",   0, 5'b00100, 5'b00000, 0, 5'b00100, 0);
    step("w_bp2",   0, 5'b00100, 5'b00000, 0, 5'b00100, 0);
    step("w_bp3",   0, 5'b00100, 5'b00000, 0, 5'b00100, 0);
    step("w_drop",  0, 5'b01000, 5'b00000, 1, 5'b00100, 0);
    step("w_f2",    0, 5'b01100, 5'b00000, 1, 5'b00100, 1);
    step("w_tail",  0, 5'b01100, 5'b00100, 1, 5'b00100, 1);

    // S alone with back-to-back single-flit packets
    for (int i = 0; i < 4; i++)
      step("s_solo", 0, 5'b01000, 5'b01000, 1, 5'b01000, 1);

    // hand over to N, reset mid-packet, then E from a fresh pointer
    step("s_to_n",  0, 5'b01001, 5'b01000, 1, 5'b01000, 1);
    step("n_f1",    0, 5'b00001, 5'b00000, 1, 5'b00001, 1);
    step("n_f2",    0, 5'b00001, 5'b00000, 1, 5'b00001, 1);
    step("n_rst",   1, 5'b00001, 5'b00000, 0, 5'b00001, 0);
    step("idle_e",  0, 5'b00010, 5'b00000, 1, 5'b00000, 0);
    step("e_gnt",   0, 5'b00010, 5'b00010, 1, 5'b00010, 1);

    // ptr was 2 before this reset; afterwards N must beat L
    step("rst_c",   1, 5'b00000, 5'b00000, 1, 5'b00010, 0);
    step("idle_0",  0, 5'b00000, 5'b00000, 1, 5'b00000, 0);
    step("idle_1",  0, 5'b00000, 5'b00000, 1, 5'b00000, 0);
    step("ptr_req", 0, 5'b10001, 5'b00000, 1, 5'b00000, 0);
    step("ptr_n",   0, 5'b10001, 5'b00001, 1, 5'b00001, 1);
    step("ptr_l",   0, 5'b10000, 5'b10000, 1, 5'b10000, 1);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain left %0d expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
